// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the instruction-fetch stage.
//   pcmux_selop : execute-stage PC mux select; PCMUX_TGT requests a redirect
//   fetch_tag   : per-request tag kept while a fetch is in flight
//   fetch_entry : buffered {pc, instr} pair waiting for decode
//   FETCH_DEPTH : default request/buffer credit count
package fetch_unit_pkg;

  localparam int FETCH_DEPTH = 2;

  typedef enum logic [0:0] {
    PCMUX_PC4 = 1'b0,
    PCMUX_TGT = 1'b1
  } pcmux_selop;

  // stale must stay the LSB: the tag queue marks entries by setting bit 0
  typedef struct packed {
    logic [31:0] pc;
    logic        epoch;
    logic        stale;
  } fetch_tag;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch stage's pipeline and memory signals.
//   stall/pcmux_sel/jmp_tgt       : pipeline control into fetch
//   imem_req_*                    : valid/ready request channel to memory
//   imem_resp_*                   : in-order response channel, no backpressure
//   if_id_*                       : {valid, pc, instr} to decode
// master = fetch unit side, slave = pipeline/memory environment side.
interface fetch_unit_if;

  logic                       stall;
  fetch_unit_pkg::pcmux_selop pcmux_sel;
  logic [31:0]                jmp_tgt;
  logic                       imem_req_valid;
  logic                       imem_req_ready;
  logic [31:0]                imem_req_addr;
  logic                       imem_resp_valid;
  logic [31:0]                imem_resp_data;
  logic                       if_id_valid;
  logic [31:0]                if_id_pc;
  logic [31:0]                if_id_instr;

  modport master (
    input  stall, pcmux_sel, jmp_tgt, imem_req_ready, imem_resp_valid, imem_resp_data,
    output imem_req_valid, imem_req_addr, if_id_valid, if_id_pc, if_id_instr
  );

  modport slave (
    output stall, pcmux_sel, jmp_tgt, imem_req_ready, imem_resp_valid, imem_resp_data,
    input  imem_req_valid, imem_req_addr, if_id_valid, if_id_pc, if_id_instr
  );

endinterface

// File: rtl/fetch_unit_chk.sv
// fetch_unit_chk: simulation-only protocol checks for fetch_unit.
//   clk, rst_n     : clock, synchronous active-low reset
//   i_resp_valid   : memory response strobe
//   i_drain_idle   : no post-reset responses left to discard
//   i_tq_empty     : no request tags outstanding
module fetch_unit_chk (
  input logic clk,
  input logic rst_n,
  input logic i_resp_valid,
  input logic i_drain_idle,
  input logic i_tq_empty
);

  // A response must always correspond to an outstanding request.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(i_resp_valid && i_drain_idle && i_tq_empty))
        else $error("fetch_unit_chk: response with no outstanding request");
    end
  end

endmodule

// File: rtl/fetch_unit_fifo.sv
// fetch_unit_fifo: synchronous FIFO with flush, occupancy count and a mark-all
// sideband that sets bit 0 of every stored word.
//   clk, rst_n  : clock, synchronous active-low reset
//   i_flush     : empty the FIFO (any push in the same cycle is dropped)
//   i_mark      : set bit 0 of all slots (push in the same cycle wins)
//   i_push/i_push_data, i_pop : write / read-advance strobes
//   o_head, o_count, o_empty  : head word, occupancy, empty flag
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_unit_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_mark,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage array: marking touches every slot, a push overrides its slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_mark) begin
        for (int i = 0; i < DEPTH; i++) r_mem[i][0] <= 1'b1;
      end
      if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (i_push && !i_pop)      r_count <= r_count + CW'(1);
      else if (!i_push && i_pop) r_count <= r_count - CW'(1);
      else                       r_count <= r_count;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
//   clk, rst_n : clock, synchronous active-low reset
//   io_fetch   : fetch_unit_if.master -- pipeline control in, imem request /
//                response channels, {valid, pc, instr} out to decode
// Requests carry a tag {pc, epoch, stale} in a tag queue; responses pop it and
// are dropped if they belong to an older fetch stream. Fresh instructions
// either bypass straight into the if_id registers or wait in a small buffer.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = FETCH_DEPTH
) (
  input logic           clk,
  input logic           rst_n,
  fetch_unit_if.master  io_fetch
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   L_DEPTH = (CW+1)'(DEPTH);

  logic             w_redirect;
  logic             w_credit;
  logic             w_req_valid;
  logic             w_accept;
  logic             w_drain_idle;
  logic             w_can_load;
  logic             w_resp_fresh;
  logic             w_bypass;

  logic [31:0]      r_fetch_pc;
  logic             r_epoch;
  logic [CW-1:0]    r_drain;
  logic [CW:0]      w_drain_sum;
  logic [CW:0]      w_drain_dec;
  logic [CW-1:0]    w_drain_rst;

  fetch_tag         w_tq_push_data;
  fetch_tag         w_tq_head;
  logic [CW-1:0]    w_tq_count;
  logic             w_tq_empty;
  logic             w_tq_pop;

  fetch_entry       w_buf_push_data;
  fetch_entry       w_buf_head;
  logic [CW-1:0]    w_buf_count;
  logic             w_buf_empty;
  logic             w_buf_push;
  logic             w_buf_pop;

  logic             r_if_valid;
  logic [31:0]      r_if_pc;
  logic [31:0]      r_if_instr;

  assign w_redirect   = (io_fetch.pcmux_sel == PCMUX_TGT);
  assign w_drain_idle = (r_drain == '0);

  // A slot retiring this cycle is still counted; it frees up next cycle.
  assign w_credit    = (({1'b0, w_tq_count} + {1'b0, w_buf_count}) < L_DEPTH);
  assign w_req_valid = rst_n & ~w_redirect & w_drain_idle & w_credit;
  assign w_accept    = w_req_valid & io_fetch.imem_req_ready;

  assign w_tq_push_data = '{pc: r_fetch_pc, epoch: r_epoch, stale: 1'b0};

  // While draining pre-reset responses the tag queue is not touched.
  assign w_tq_pop     = rst_n & io_fetch.imem_resp_valid & w_drain_idle & ~w_tq_empty;
  assign w_resp_fresh = w_tq_pop & ~w_redirect & ~w_tq_head.stale &
                        (w_tq_head.epoch == r_epoch);

  assign w_can_load      = ~io_fetch.stall | ~r_if_valid;
  assign w_buf_pop       = rst_n & ~w_redirect & w_can_load & ~w_buf_empty;
  assign w_bypass        = w_resp_fresh & w_can_load & w_buf_empty;
  assign w_buf_push      = w_resp_fresh & ~w_bypass;
  assign w_buf_push_data = '{pc: w_tq_head.pc, instr: io_fetch.imem_resp_data};

  assign io_fetch.imem_req_valid = w_req_valid;
  assign io_fetch.imem_req_addr  = r_fetch_pc;
  assign io_fetch.if_id_valid    = r_if_valid;
  assign io_fetch.if_id_pc       = r_if_pc;
  assign io_fetch.if_id_instr    = r_if_instr;

  // Tag queue; a redirect marks every outstanding tag stale so even a second
  // redirect (epoch back to its old value) cannot resurrect old responses.
  fetch_unit_fifo #(.WIDTH($bits(fetch_tag)), .DEPTH(DEPTH)) u_tag_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (1'b0),
    .i_mark      (w_redirect),
    .i_push      (w_accept),
    .i_push_data (w_tq_push_data),
    .i_pop       (w_tq_pop),
    .o_head      (w_tq_head),
    .o_count     (w_tq_count),
    .o_empty     (w_tq_empty)
  );

  fetch_unit_fifo #(.WIDTH($bits(fetch_entry)), .DEPTH(DEPTH)) u_instr_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (w_redirect),
    .i_mark      (1'b0),
    .i_push      (w_buf_push),
    .i_push_data (w_buf_push_data),
    .i_pop       (w_buf_pop),
    .o_head      (w_buf_head),
    .o_count     (w_buf_count),
    .o_empty     (w_buf_empty)
  );

  // Outstanding requests at reset become responses to discard afterwards;
  // responses arriving during reset already count against them.
  always_comb begin
    w_drain_sum = {1'b0, w_tq_count} + {1'b0, r_drain};
    if (io_fetch.imem_resp_valid && (w_drain_sum != '0)) w_drain_dec = w_drain_sum - (CW+1)'(1);
    else                                                 w_drain_dec = w_drain_sum;
    if (w_drain_dec > L_DEPTH) w_drain_rst = L_DEPTH[CW-1:0];
    else                       w_drain_rst = w_drain_dec[CW-1:0];
  end

  // Fetch PC, epoch and post-reset drain counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_epoch    <= 1'b0;
      r_drain    <= w_drain_rst;
    end else begin
      if (io_fetch.imem_resp_valid && !w_drain_idle) r_drain <= r_drain - CW'(1);
      else                                           r_drain <= r_drain;
      if (w_redirect) begin
        r_fetch_pc <= align_word(io_fetch.jmp_tgt);
        r_epoch    <= ~r_epoch;
      end else if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_epoch    <= r_epoch;
      end else begin
        r_fetch_pc <= r_fetch_pc;
        r_epoch    <= r_epoch;
      end
    end
  end

  // if_id registers: buffer head first (keeps order), then bypass, else bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= 32'h0000_0000;
      r_if_instr <= 32'h0000_0000;
    end else if (w_redirect) begin
      r_if_valid <= 1'b0;
    end else if (w_can_load) begin
      if (!w_buf_empty) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= w_buf_head.pc;
        r_if_instr <= w_buf_head.instr;
      end else if (w_bypass) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= w_tq_head.pc;
        r_if_instr <= io_fetch.imem_resp_data;
      end else begin
        r_if_valid <= 1'b0;
      end
    end else begin
      r_if_valid <= r_if_valid;
    end
  end

  fetch_unit_chk u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_resp_valid (io_fetch.imem_resp_valid),
    .i_drain_idle (w_drain_idle),
    .i_tq_empty   (w_tq_empty)
  );

endmodule
